// File: rtl/fetchflare_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetchflare_rr_arbiter: registered round-robin grant for prefetch slots |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module fetchflare_rr_arbiter #(
    parameter  int WIDTH = 16,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req_i,
    input  logic             gnt_ready_i,
    output logic             gnt_valid_o,
    output logic [WIDTH-1:0] gnt_o,
    output logic [IDXW-1:0]  gnt_idx_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic              gnt_valid;
    logic [WIDTH-1:0]  gnt;
    logic [IDXW-1:0]   gnt_idx;

    logic [IDXW:0]     k_inc;
    logic [IDXW-1:0]   nxt_ptr;
    logic [IDXW-1:0]   arb_ptr;
    logic [WIDTH-1:0]  win;
    logic [IDXW-1:0]   win_idx;

    // Prefix-OR from bit 0 upward: t[i] = |v[i:0].
    function automatic logic [WIDTH-1:0] thermo(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        t[0] = v[0];
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] | v[i];
        end
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] lowest(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        t = thermo(v);
        return t & ~(t << 1);
    endfunction

    function automatic logic [IDXW-1:0] to_idx(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        return idx;
    endfunction

    // Extra bit on the increment so the wrap compare is exact for any WIDTH.
    always_comb begin
        k_inc   = {1'b0, gnt_idx} + (IDXW+1)'(1);
        nxt_ptr = (k_inc == (IDXW+1)'(WIDTH)) ? '0 : k_inc[IDXW-1:0];
    end

    // In GRANT the only arbitration that matters happens on an accept,
    // so it is evaluated against the post-accept pointer.
    always_comb begin
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] masked;
        arb_ptr = (state == GRANT) ? nxt_ptr : ptr;
        mask    = thermo(WIDTH'(1) << arb_ptr);
        masked  = req_i & mask;
        win     = lowest((|masked) ? masked : req_i);
        win_idx = to_idx(win);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
            gnt_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        state     <= GRANT;
                        gnt_valid <= 1'b1;
                        gnt       <= win;
                        gnt_idx   <= win_idx;
                    end
                end
                GRANT: begin
                    if (gnt_ready_i) begin
                        ptr <= nxt_ptr;
                        if (|req_i) begin
                            gnt     <= win;
                            gnt_idx <= win_idx;
                        end else begin
                            state     <= IDLE;
                            gnt_valid <= 1'b0;
                            gnt       <= '0;
                            gnt_idx   <= '0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                    gnt       <= '0;
                    gnt_idx   <= '0;
                end
            endcase
        end
    end

    assign gnt_valid_o = gnt_valid;
    assign gnt_o       = gnt;
    assign gnt_idx_o   = gnt_idx;

endmodule
`default_nettype wire

// File: tb/tb_fetchflare_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fetchflare_rr_arbiter: scoreboard bench for the round-robin arbiter |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_fetchflare_rr_arbiter;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] req_i;
    logic             gnt_ready_i;
    logic             gnt_valid_o;
    logic [WIDTH-1:0] gnt_o;
    logic [IDXW-1:0]  gnt_idx_o;

    always #5 clk = ~clk;

    fetchflare_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .gnt_ready_i (gnt_ready_i),
        .gnt_valid_o (gnt_valid_o),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o)
    );

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] gnt;
        logic [IDXW-1:0]  idx;
        logic [IDXW-1:0]  ptr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic m_valid = 1'b0;
    int   m_idx   = 0;
    int   m_ptr   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Circular search starting at the pointer.
    function automatic int rr_pick(input logic [WIDTH-1:0] r, input int p);
        for (int j = 0; j < WIDTH; j++) begin
            int c;
            c = (p + j) % WIDTH;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic step(input logic [WIDTH-1:0] r, input logic rdy, input logic rst);
        exp_t e;
        @(negedge clk);
        req_i       = r;
        gnt_ready_i = rdy;
        reset       = rst;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
        end else if (!m_valid) begin
            if (r != '0) begin
                m_valid = 1'b1;
                m_idx   = rr_pick(r, m_ptr);
            end
        end else if (rdy) begin
            m_ptr = (m_idx + 1) % WIDTH;
            if (r != '0) begin
                m_idx = rr_pick(r, m_ptr);
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
        e.valid = m_valid;
        e.gnt   = m_valid ? (WIDTH'(1) << m_idx) : '0;
        e.idx   = IDXW'(m_idx);
        e.ptr   = IDXW'(m_ptr);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("valid", 64'(gnt_valid_o), 64'(e.valid));
        check("gnt", 64'(gnt_o), 64'(e.gnt));
        check("idx", 64'(gnt_idx_o), 64'(e.idx));
        check("ptr", 64'(dut.ptr), 64'(e.ptr));
        check("onehot0", 64'($onehot0(gnt_o)), 64'd1);
    endtask

    initial begin
        reset       = 1'b1;
        req_i       = '0;
        gnt_ready_i = 1'b0;

        // Reset state, with ready high to show it is ignored
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        check("reset_valid", 64'(gnt_valid_o), 64'd0);
        check("reset_gnt", 64'(gnt_o), 64'd0);

        // Single requester 5, re-granted every cycle
        step(16'h0020, 1'b1, 1'b0);
        check("single_idx", 64'(gnt_idx_o), 64'd5);
        step(16'h0020, 1'b1, 1'b0);
        check("single_ptr", 64'(dut.ptr), 64'd6);
        check("single_gnt", 64'(gnt_o), 64'h0020);
        step(16'h0020, 1'b1, 1'b0);
        step(16'h0020, 1'b1, 1'b0);

        // All requesting: 0..15,0,1
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            step(16'hFFFF, 1'b1, 1'b0);
            check("all_seq", 64'(gnt_idx_o), 64'(i % WIDTH));
        end

        // Backpressure: idx 1 held five cycles, then 2
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(16'h0006, 1'b0, 1'b0);
            check("bp_hold", 64'(gnt_idx_o), 64'd1);
        end
        step(16'h0006, 1'b1, 1'b0);
        check("bp_next", 64'(gnt_idx_o), 64'd2);
        step(16'h0006, 1'b1, 1'b0);

        // Wrap and drop
        step('0, 1'b0, 1'b1);
        step(16'h4000, 1'b0, 1'b0);
        step(16'h8001, 1'b1, 1'b0);
        check("wrap_15", 64'(gnt_idx_o), 64'd15);
        step(16'h0001, 1'b0, 1'b0);
        step(16'h0001, 1'b0, 1'b0);
        check("drop_hold", 64'(gnt_idx_o), 64'd15);
        step(16'h0001, 1'b1, 1'b0);
        check("wrap_0", 64'(gnt_idx_o), 64'd0);
        step('0, 1'b1, 1'b0);

        // Idle return
        step(16'h0010, 1'b1, 1'b0);
        check("idle_idx", 64'(gnt_idx_o), 64'd4);
        step('0, 1'b1, 1'b0);
        check("idle_valid", 64'(gnt_valid_o), 64'd0);
        step('0, 1'b1, 1'b0);

        // Reset mid-operation
        step(16'hFFFF, 1'b1, 1'b0);
        step(16'hFFFF, 1'b1, 1'b0);
        step(16'hFFFF, 1'b1, 1'b1);
        check("rst_mid_valid", 64'(gnt_valid_o), 64'd0);
        check("rst_mid_ptr", 64'(dut.ptr), 64'd0);
        step(16'hFFFF, 1'b1, 1'b0);
        check("rst_mid_first", 64'(gnt_idx_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] r;
            r = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) r = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            step(r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
